// File: rtl/sum_acc_pkg.sv
// Shared types and constants for the 2-bit-adder sample accumulator.
package sum_acc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam int SAMPLE_W      = 3;
    localparam int SUM_W_DEF     = 8;
    localparam int N_SAMPLES_DEF = 4;

endpackage

// File: rtl/sum_acc_add.sv
// SUM_W-bit accumulate adder; wraps by default, clamps to all-ones when SUM_ACC_SAT_EN is defined.
module sum_acc_add
    import sum_acc_pkg::*;
#(
    parameter int SUM_W = SUM_W_DEF
) (
    input  logic [SUM_W-1:0]    acc,
    input  logic [SAMPLE_W-1:0] sample,
    output logic [SUM_W-1:0]    next_acc,
    output logic                carry
);

    logic [SUM_W:0] raw;

    always_comb begin
        raw   = {1'b0, acc} + (SUM_W+1)'(sample);
        carry = raw[SUM_W];
`ifdef SUM_ACC_SAT_EN
        next_acc = carry ? '1 : raw[SUM_W-1:0];
`else
        next_acc = raw[SUM_W-1:0];
`endif
    end

endmodule

// File: rtl/sum_accumulator.sv
// Sums N_SAMPLES 3-bit {carry,sum} samples into one SUM_W result with a valid/ready handshake.
// Optional macro SUM_ACC_SAT_EN selects saturating instead of wrapping accumulation.
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int SUM_W     = SUM_W_DEF,
    parameter int N_SAMPLES = N_SAMPLES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_z,
    input  logic             in_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_sum,
    output logic             out_ovf,
    output logic             busy
);

    localparam int CNT_W = $clog2(N_SAMPLES + 1);

    state_e              state_q, state_d;
    logic [SUM_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                out_valid_q;
    logic                in_ready_q;
    logic                busy_q;

    logic [SAMPLE_W-1:0] sample;
    logic [SUM_W-1:0]    add_next;
    logic                add_carry;
    logic                xfer;

    assign sample = {in_c, in_z};
    assign xfer   = in_valid && in_ready_q;

    sum_acc_add #(
        .SUM_W (SUM_W)
    ) u_add (
        .acc      (acc_q),
        .sample   (sample),
        .next_acc (add_next),
        .carry    (add_carry)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    acc_d   = SUM_W'(sample);
                    cnt_d   = CNT_W'(1);
                    ovf_d   = 1'b0;
                    state_d = (N_SAMPLES == 1) ? HOLD : ACC;
                end
            end
            ACC: begin
                if (xfer) begin
                    acc_d = add_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    ovf_d = ovf_q | add_carry;
                    if (cnt_q + CNT_W'(1) == CNT_W'(N_SAMPLES)) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // Release only; no sample is taken on the releasing cycle.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= (state_d == HOLD);
            in_ready_q  <= (state_d != HOLD);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = acc_q;
    assign out_ovf   = ovf_q;
    assign busy      = busy_q;

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
- REQ-001 SHALL have parameter SUM_W, default 8: accumulator/result width in bits; legal range is SUM_W >= 3.
- REQ-002 SHALL have parameter N_SAMPLES, default 4: number of samples summed per result; legal range is N_SAMPLES >= 1.
- REQ-003 SHALL use one clock and an asynchronous, active-low reset; all state is clocked on the rising edge of clk.
- REQ-004 clk  input  1  system clock.
- REQ-005 rst_n  input  1  asynchronous active-low reset.
- REQ-006 in_valid  input  1  upstream adder sample present.
- REQ-007 in_ready  output  1  block accepts sample this cycle.
- REQ-008 in_z  input  2  2-bit adder sum.
- REQ-009 in_c  input  1  2-bit adder carry.
- REQ-010 out_valid  output  1  result available.
- REQ-011 out_ready  input  1  downstream takes result.
- REQ-012 out_sum  output  SUM_W  accumulated result.
- REQ-013 out_ovf  output  1  overflow occurred in this result.
- REQ-014 busy  output  1  high when state is not IDLE.

Function
- REQ-015 SHALL form sample = {in_c, in_z}, 3 bits unsigned (0..6), zero-extended to SUM_W.
- REQ-016 SHALL accept a sample only on a cycle with in_valid && in_ready (a transfer).
- REQ-017 SHALL implement FSM states IDLE, ACC and HOLD.
- REQ-018 IDLE: in_ready=1. A transfer SHALL load acc=sample, cnt=1 and ovf=0, then go to HOLD if N_SAMPLES==1, else to ACC.
- REQ-019 ACC: in_ready=1. A transfer SHALL do acc+=sample and cnt+=1; the transfer that makes cnt==N_SAMPLES SHALL move the FSM to HOLD.
- REQ-020 ACC: cycles without in_valid SHALL hold all state; there is no timeout.
- REQ-021 HOLD: in_ready=0 and out_valid=1; out_sum and out_ovf SHALL stay stable until out_ready=1.
- REQ-022 HOLD with out_ready=1: the FSM SHALL go to IDLE next cycle, and out_valid SHALL drop that cycle.
- REQ-023 out_valid SHALL assert the cycle after the Nth transfer (latency 1), independent of out_ready.
- REQ-024 In HOLD, in_valid SHALL be ignored; the upstream holds its data (no loss, no double count).
- REQ-025 SHALL not accept a new sample in the same cycle that HOLD is released (no bypass).
- REQ-026 out_ovf SHALL be sticky within one result: set when any addition carries beyond SUM_W bits, cleared on the next IDLE load.
- REQ-027 out_sum SHALL equal acc in every state; it is only meaningful while out_valid=1.

Reset
- REQ-028 rst_n=0 SHALL force, asynchronously: state=IDLE, acc=0, cnt=0, ovf=0, out_valid=0, busy=0; in_ready SHALL be 1 once reset is released.
- REQ-029 Reset mid-accumulation or in HOLD SHALL discard the partial or pending result, with no output emitted.

Configuration
- REQ-030 Macro SUM_ACC_SAT_EN defined: an overflowing addition SHALL clamp acc to 2^SUM_W-1 and set ovf; later additions keep acc clamped.
- REQ-031 Macro SUM_ACC_SAT_EN undefined: an overflowing addition SHALL wrap acc modulo 2^SUM_W and set ovf.

Structure
- REQ-032 Package sum_acc_pkg SHALL hold the state enum (IDLE/ACC/HOLD), the sample width constant (3) and the default SUM_W and N_SAMPLES values.
- REQ-033 Sub-module sum_acc_add SHALL hold the SUM_W adder: inputs acc and sample; outputs next_acc and carry. Wrap or saturate is selected by SUM_ACC_SAT_EN.
- REQ-034 Counter width SHALL be $clog2(N_SAMPLES+1).

Verification
- REQ-035 Defaults; 4 back-to-back samples z=2, c=1 (value 6) -> out_valid the cycle after the 4th, out_sum=24, out_ovf=0.
- REQ-036 Samples 1,0,3,2 with in_valid gaps of 2 cycles; out_ready held 0 for 3 cycles -> out_sum=6 stable, in_ready=0 throughout HOLD, release returns to IDLE.
- REQ-037 SUM_W=4, 4×6 -> wrap build: out_sum=8, out_ovf=1; SUM_ACC_SAT_EN build: out_sum=15, out_ovf=1.
- REQ-038 N_SAMPLES=1; stream of 3 samples 5,6,4 -> three results 5,6,4, each occupying IDLE->HOLD->IDLE, with no sample lost.
- REQ-039 rst_n pulsed low after 2 of 4 samples -> busy=0 and out_valid=0 immediately; the next 4 samples of 1 -> out_sum=4.
- REQ-040 Overflow then new result: overflowing result followed by 4×1 -> second result out_ovf=0, out_sum=4.
